plic_claim_ctrl: RTL

//  Interrupt gateway + claim/complete sequencer for the PLIC. Captures per-source requests into

---
 rtl/plic_claim_ctrl_if.sv | 38 +++
 rtl/plic_claim_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/plic_claim_ctrl_if.sv
// Claim/complete bus between the PLIC claim controller (slave) and the CPU/config side (master).
// Carries raw IRQ lines, config registers, the claim/complete pulses and status read-back.
interface plic_claim_ctrl_if #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
);
  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        irq_src;
  logic [NUM_SRC-1:0]        irq_en;
  logic [NUM_SRC*PRIO_W-1:0] prio_cfg;
  logic [PRIO_W-1:0]         threshold;
  logic                      I_flag;
  logic                      claim_req;
  logic                      complete_req;
  logic [ID_W-1:0]           complete_id;
  logic                      intr_ev;
  logic                      claim_valid;
  logic [ID_W-1:0]           claim_id;
  logic [NUM_SRC-1:0]        pending;
  logic                      cmpl_err;
  logic [1:0]                dbg_state;

  // Handshake: intr_ev acts as "valid" for a claim; claim_req is a 1-cycle "ready" pulse that
  // takes effect only while intr_ev's underlying state is SIGNAL. claim_valid then stays high
  // until a complete_req pulse carries the matching complete_id; any other complete is rejected.
  modport master (
    output irq_src, irq_en, prio_cfg, threshold, I_flag,
    output claim_req, complete_req, complete_id,
    input  intr_ev, claim_valid, claim_id, pending, cmpl_err, dbg_state
  );

  modport slave (
    input  irq_src, irq_en, prio_cfg, threshold, I_flag,
    input  claim_req, complete_req, complete_id,
    output intr_ev, claim_valid, claim_id, pending, cmpl_err, dbg_state
  );
endinterface

// File: rtl/plic_claim_ctrl.sv
// PLIC gateway + claim/complete sequencer: pending capture, priority arbiter, IDLE/SIGNAL/SERVICE FSM.
// Optional macro PLIC_LEVEL_TRIG_EN switches the gateway from edge-triggered to level-sampled.
module plic_claim_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input logic               pclk,
  input logic               preset_n,
  plic_claim_ctrl_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SIGNAL  = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               claim_valid_q, claim_valid_d;
  logic [ID_W-1:0]    claim_id_q, claim_id_d;
  logic               cmpl_err_q, cmpl_err_d;
`ifndef PLIC_LEVEL_TRIG_EN
  logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
`endif

  logic [PRIO_W-1:0]  prio [NUM_SRC];
  logic [NUM_SRC-1:0] eligible;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;
  logic               claim_fire;
  logic               complete_ok;

  // Strict ">" while scanning upward keeps the lowest index on priority ties.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    win_prio  = '0;
    eligible  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      prio[k]     = bus.prio_cfg[k*PRIO_W +: PRIO_W];
      eligible[k] = pending_q[k] & bus.irq_en[k] & (prio[k] > bus.threshold);
      if (eligible[k] && (!win_valid || (prio[k] > win_prio))) begin
        win_valid = 1'b1;
        win_id    = ID_W'(k);
        win_prio  = prio[k];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    claim_valid_d = claim_valid_q;
    claim_id_d    = claim_id_q;
    claim_fire    = 1'b0;
    complete_ok   = (state_q == S_SERVICE) && bus.complete_req &&
                    (bus.complete_id == claim_id_q);
    cmpl_err_d    = bus.complete_req && !complete_ok;

    case (state_q)
      S_IDLE: begin
        if (win_valid) state_d = S_SIGNAL;
      end
      S_SIGNAL: begin
        if (!win_valid) begin
          state_d = S_IDLE;
        end else if (bus.claim_req) begin
          claim_fire    = 1'b1;
          claim_id_d    = win_id;
          claim_valid_d = 1'b1;
          state_d       = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (complete_ok) begin
          claim_valid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef PLIC_LEVEL_TRIG_EN
  // Level mode: mirror the line, but mask whichever source is (or is becoming) in service.
  always_comb begin
    pending_d = bus.irq_src &
                ~(NUM_SRC'(claim_valid_d) << claim_id_d);
  end
`else
  // Set wins over the claim clear when an edge lands in the claim cycle.
  always_comb begin
    irq_prev_d = bus.irq_src;
    pending_d  = (pending_q & ~(NUM_SRC'(claim_fire) << win_id)) |
                 (bus.irq_src & ~irq_prev_q);
  end
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
      cmpl_err_q    <= 1'b0;
`ifndef PLIC_LEVEL_TRIG_EN
      irq_prev_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
      cmpl_err_q    <= cmpl_err_d;
`ifndef PLIC_LEVEL_TRIG_EN
      irq_prev_q    <= irq_prev_d;
`endif
    end
  end

  assign bus.intr_ev     = (state_q == S_SIGNAL) & bus.I_flag;
  assign bus.claim_valid = claim_valid_q;
  assign bus.claim_id    = claim_id_q;
  assign bus.pending     = pending_q;
  assign bus.cmpl_err    = cmpl_err_q;
  assign bus.dbg_state   = state_q;
endmodule
